mem_port_arbiter: RTL and testbench
===================================

# mem_port_arbiter

Shares the single-port unified instruction/data memory between the fetch stage (IF, read-only) and the memory stage (MEM, read/write) of the MIPS pipeline. It serialises accesses, runs a fixed-latency memory cycle for each grant, and returns read data with a one-cycle ready pulse to the owning requester. On contention it alternates ownership (round-robin), and the first contention after reset goes to MEM. The pipeline stall logic uses the ready pulses to hold IF/MEM until their access completes.

## Interface
- ADDR_W, 32, address width in bits (byte address, passed through unchanged)
- DATA_W, 32, data width
- LAT, 3, memory access cycles per grant; legal range 1..15

- clk  in  1  clock, all state updates on rising edge
- rst  in  1  reset, asynchronous, active-high
- if_req  in  1  fetch request; held high until if_ready
- if_addr  in  ADDR_W  fetch address; stable while if_req high
- if_ready  out  1  one-cycle pulse: fetch complete, rdata valid
- dm_req  in  1  data request; held high until dm_ready
- dm_we  in  1  1 = store, 0 = load; stable while dm_req high
- dm_addr  in  ADDR_W  data address
- dm_wdata  in  DATA_W  store data
- dm_ready  out  1  one-cycle pulse: data access complete
- rdata  out  DATA_W  registered read data, valid in the ready cycle, held until next capture
- busy  out  1  high whenever state is not IDLE
- mem_en  out  1  memory enable
- mem_we  out  1  memory write strobe
- mem_addr  out  ADDR_W  latched address
- mem_wdata  out  DATA_W  latched write data
- mem_rdata  in  DATA_W  memory read data, valid in the final access cycle

## Operation
- States: IDLE, ACCESS, DONE.
- IDLE: no request -> stay. Only if_req -> owner = IF. Only dm_req -> owner = DM. Both -> owner = opposite of last_owner. Then latch addr/we/wdata from the owner (IF forces we = 0), clear count, go ACCESS, set last_owner = owner.
- ACCESS: mem_en = 1 and mem_addr/mem_wdata come from latches. count increments each cycle. At count == LAT-1: capture mem_rdata into rdata on a load (rdata unchanged on a store), go DONE.
- mem_we = latched we AND (count == LAT-1). The write strobe is only in the final access cycle, so a reset before that cycle commits no write.
- DONE: assert if_ready or dm_ready for the owner (never both). Go IDLE unconditionally. A requester drops or replaces its request at the edge that ends DONE, and IDLE samples the fresh value.
- Requests that change or drop while not granted are legal. Address/data are sampled only in IDLE.
- count width is 4 bits; it never wraps because it is cleared on entry to ACCESS.

## Timing
- Request high in IDLE cycle t -> ACCESS cycles t+1..t+LAT -> ready in cycle t+LAT+1. Total latency is LAT+2 cycles.
- Back-to-back: the next grant is earliest at IDLE t+LAT+2, so throughput is one access per LAT+2 cycles.
- Reset (any time, including mid-ACCESS): state = IDLE, count = 0, last_owner = IF (so DM wins the first contention), latches = 0, rdata = 0, if_ready = dm_ready = busy = mem_en = mem_we = 0, mem_addr = mem_wdata = 0. The in-flight access is abandoned with no ready pulse. Requesters re-issue it.
- All outputs are registered or decoded from registered state only. There is no combinational path from any input to any output.

## Structure
- Package mips_mem_pkg:
  - state enum (IDLE, ACCESS, DONE)
  - owner encoding (OWN_IF = 0, OWN_DM = 1)
  - default LAT constant, shared with the memory model
- Sub-module mem_wait_counter: clear/enable inputs, 4-bit count, terminal flag at LAT-1.
- Everything else (FSM, arbitration, latches) lives in the top module.

## Test plan
- Single fetch, LAT = 3: if_req high at cycle 0 with if_addr 0x0040_0000 and mem_rdata 0x2008_0005 -> mem_en cycles 1–3, if_ready and rdata = 0x2008_0005 in cycle 4, mem_we never high.
- Single store: dm_req, dm_we = 1, addr 0x1001_0004, wdata 0xDEAD_BEEF -> mem_we high only in cycle 3, dm_ready in cycle 4, rdata unchanged.
- Contention: both requests held continuously from reset -> grant order is DM, IF, DM, IF, with ready pulses at cycles 4, 9, 14, 19.
- Reset mid-store: assert rst at cycle 2 of a store -> mem_we never asserts, no dm_ready, all outputs 0. Re-issuing the store completes normally.
- Request drop: if_req pulsed high only during a DM access -> IF is not granted afterward, and the arbiter returns to IDLE with busy = 0.
- LAT = 1 build: a load completes with ready at cycle 2, and mem_en is high for exactly one cycle.

Source files
------------

// File: rtl/mips_mem_pkg.sv
// Shared types and constants for the unified memory port arbiter
// and the memory model that sits behind it.
package mips_mem_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    DONE
  } state_e;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_DM = 1'b1
  } owner_e;

  localparam int DEF_LAT = 3;
  localparam int CNT_W   = 4;

endpackage

// File: rtl/mem_wait_counter.sv
// Access-cycle counter: counts cycles of one memory access and
// flags the final cycle (count == LAT-1).
module mem_wait_counter
  import mips_mem_pkg::*;
#(
  parameter int LAT = DEF_LAT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  output logic [CNT_W-1:0] count,
  output logic             term
);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (en) begin
      count_d = count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;
  assign term  = (count_q == CNT_W'(LAT - 1));

endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one single-port memory between
// instruction fetch (read-only) and the data memory stage.
module mem_port_arbiter
  import mips_mem_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int LAT    = DEF_LAT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_ready,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic              dm_ready,
  output logic [DATA_W-1:0] rdata,
  output logic              busy,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  state_e            state_q, state_d;
  owner_e            owner_q, owner_d;
  owner_e            last_q, last_d;
  owner_e            grant;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              cnt_clr;
  logic              cnt_en;
  logic              cnt_term;
  logic [CNT_W-1:0]  cnt;

  mem_wait_counter #(
    .LAT (LAT)
  ) u_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr   (cnt_clr),
    .en    (cnt_en),
    .count (cnt),
    .term  (cnt_term)
  );

  // On contention the owner that did not go last wins.
  always_comb begin
    grant = OWN_IF;
    if (if_req && dm_req) begin
      grant = (last_q == OWN_IF) ? OWN_DM : OWN_IF;
    end else if (dm_req) begin
      grant = OWN_DM;
    end
  end

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    last_d  = last_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    cnt_clr = 1'b0;
    cnt_en  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (if_req || dm_req) begin
          owner_d = grant;
          last_d  = grant;
          if (grant == OWN_DM) begin
            we_d    = dm_we;
            addr_d  = dm_addr;
            wdata_d = dm_wdata;
          end else begin
            we_d    = 1'b0;
            addr_d  = if_addr;
            wdata_d = '0;
          end
          cnt_clr = 1'b1;
          state_d = ACCESS;
        end
      end
      ACCESS: begin
        cnt_en = 1'b1;
        if (cnt_term) begin
          if (!we_q) begin
            rdata_d = mem_rdata;
          end
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      owner_q <= OWN_IF;
      last_q  <= OWN_IF;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
    end
  end

  assign busy      = (state_q != IDLE);
  assign mem_en    = (state_q == ACCESS);
  assign mem_we    = mem_en && we_q && cnt_term;
  assign if_ready  = (state_q == DONE) && (owner_q == OWN_IF);
  assign dm_ready  = (state_q == DONE) && (owner_q == OWN_DM);
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign rdata     = rdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios plus
// a randomized run against a transaction-level reference model.
module tb_mem_port_arbiter;

  localparam int AW   = 32;
  localparam int DW   = 32;
  localparam int LAT  = 3;
  localparam int NCYC = 600;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          if_req = 1'b0;
  logic [AW-1:0] if_addr = '0;
  logic          dm_req = 1'b0;
  logic          dm_we = 1'b0;
  logic [AW-1:0] dm_addr = '0;
  logic [DW-1:0] dm_wdata = '0;
  logic [DW-1:0] mem_rdata;

  logic          if_ready, dm_ready, busy, mem_en, mem_we;
  logic [DW-1:0] rdata, mem_wdata;
  logic [AW-1:0] mem_addr;

  logic          if_ready_1, dm_ready_1, busy_1, mem_en_1, mem_we_1;
  logic [DW-1:0] rdata_1, mem_wdata_1;
  logic [AW-1:0] mem_addr_1;

  logic          use_mem = 1'b0;
  logic [DW-1:0] fixed_rdata = '0;
  logic [DW-1:0] tbmem [16];

  logic [4:0] st;
  logic [4:0] st1;

  int passed = 0;
  int total  = 0;

  assign st  = {busy, mem_en, mem_we, if_ready, dm_ready};
  assign st1 = {busy_1, mem_en_1, mem_we_1, if_ready_1, dm_ready_1};

  always #5 clk = ~clk;

  assign mem_rdata = use_mem ? tbmem[mem_addr[5:2]] : fixed_rdata;

  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 16; i++) tbmem[i] <= 32'hA5A5_0000 | i;
    end else if (use_mem && mem_we) begin
      tbmem[mem_addr[5:2]] <= mem_wdata;
    end
  end

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .LAT(LAT)) u_dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_ready(if_ready),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr),
    .dm_wdata(dm_wdata), .dm_ready(dm_ready),
    .rdata(rdata), .busy(busy), .mem_en(mem_en), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .LAT(1)) u_dut1 (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_ready(if_ready_1),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr),
    .dm_wdata(dm_wdata), .dm_ready(dm_ready_1),
    .rdata(rdata_1), .busy(busy_1), .mem_en(mem_en_1),
    .mem_we(mem_we_1), .mem_addr(mem_addr_1),
    .mem_wdata(mem_wdata_1), .mem_rdata(mem_rdata)
  );

  // Leaves the bench at a falling edge of cycle 0 (IDLE, reset released).
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    if_req = 1'b0; if_addr = '0;
    dm_req = 1'b0; dm_we = 1'b0; dm_addr = '0; dm_wdata = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    total++;
    if (st !== 5'b0) $display("FAIL reset_ctl got %b exp 00000", st);
    else passed++;
    total++;
    if ({rdata, mem_addr, mem_wdata} !== '0)
      $display("FAIL reset_data got %h %h %h exp 0", rdata, mem_addr, mem_wdata);
    else passed++;
    total++;
    if (st1 !== 5'b0) $display("FAIL reset_ctl_lat1 got %b exp 00000", st1);
    else passed++;
    rst = 1'b0;
    @(negedge clk);
    total++;
    if (st !== 5'b0) $display("FAIL reset_idle got %b exp 00000", st);
    else passed++;
  endtask

  task automatic test_fetch();
    logic [4:0] exp;
    do_reset();
    fixed_rdata = 32'h2008_0005;
    if_addr = 32'h0040_0000;
    if_req = 1'b1;
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      exp = {c <= 4, c <= 3, 1'b0, c == 4, 1'b0};
      total++;
      if (st !== exp) $display("FAIL fetch_ctl c=%0d got %b exp %b", c, st, exp);
      else passed++;
      if (c == 2) begin
        total++;
        if (mem_addr !== 32'h0040_0000)
          $display("FAIL fetch_addr got %h exp 00400000", mem_addr);
        else passed++;
      end
      if (c == 4) begin
        total++;
        if (rdata !== 32'h2008_0005)
          $display("FAIL fetch_rdata got %h exp 20080005", rdata);
        else passed++;
        if_req = 1'b0;
      end
    end
  endtask

  // Runs straight after test_fetch so the earlier rdata must survive.
  task automatic test_store();
    logic [4:0] exp;
    fixed_rdata = 32'h5555_AAAA;
    dm_addr = 32'h1001_0004;
    dm_wdata = 32'hDEAD_BEEF;
    dm_we = 1'b1;
    dm_req = 1'b1;
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      exp = {c <= 4, c <= 3, c == 3, 1'b0, c == 4};
      total++;
      if (st !== exp) $display("FAIL store_ctl c=%0d got %b exp %b", c, st, exp);
      else passed++;
      if (c == 3) begin
        total++;
        if ({mem_addr, mem_wdata} !== {32'h1001_0004, 32'hDEAD_BEEF})
          $display("FAIL store_bus got %h %h exp 10010004 deadbeef",
                   mem_addr, mem_wdata);
        else passed++;
      end
      if (c == 4) begin
        total++;
        if (rdata !== 32'h2008_0005)
          $display("FAIL store_rdata got %h exp 20080005", rdata);
        else passed++;
        dm_req = 1'b0;
        dm_we = 1'b0;
      end
    end
  endtask

  task automatic test_contention();
    logic [1:0] exp;
    logic       eb;
    do_reset();
    fixed_rdata = 32'h0;
    if_addr = 32'h0040_0010;
    dm_addr = 32'h1001_0020;
    dm_we = 1'b0;
    if_req = 1'b1;
    dm_req = 1'b1;
    for (int c = 1; c <= 24; c++) begin
      @(negedge clk);
      exp = {c == 9 || c == 19, c == 4 || c == 14};
      total++;
      if ({if_ready, dm_ready} !== exp)
        $display("FAIL contend_ready c=%0d got %b exp %b",
                 c, {if_ready, dm_ready}, exp);
      else passed++;
      eb = (c <= 19) && (c % 5 != 0);
      total++;
      if (busy !== eb) $display("FAIL contend_busy c=%0d got %b exp %b", c, busy, eb);
      else passed++;
      if (c == 1 || c == 11) begin
        total++;
        if (mem_addr !== 32'h1001_0020)
          $display("FAIL contend_dm_owner c=%0d got %h exp 10010020", c, mem_addr);
        else passed++;
      end
      if (c == 6 || c == 16) begin
        total++;
        if (mem_addr !== 32'h0040_0010)
          $display("FAIL contend_if_owner c=%0d got %h exp 00400010", c, mem_addr);
        else passed++;
      end
      if (c == 19) begin
        if_req = 1'b0;
        dm_req = 1'b0;
      end
    end
  endtask

  task automatic test_reset_mid_store();
    logic [4:0] exp;
    do_reset();
    dm_addr = 32'h1001_0004;
    dm_wdata = 32'hDEAD_BEEF;
    dm_we = 1'b1;
    dm_req = 1'b1;
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      if (c <= 2) exp = 5'b11000;
      else exp = 5'b00000;
      total++;
      if (st !== exp) $display("FAIL rstmid_ctl c=%0d got %b exp %b", c, st, exp);
      else passed++;
      if (c >= 3) begin
        total++;
        if ({rdata, mem_addr, mem_wdata} !== '0)
          $display("FAIL rstmid_data c=%0d got %h %h %h exp 0",
                   c, rdata, mem_addr, mem_wdata);
        else passed++;
      end
      if (c == 2) rst = 1'b1;
      if (c == 5) rst = 1'b0;
    end
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      exp = {c <= 4, c <= 3, c == 3, 1'b0, c == 4};
      total++;
      if (st !== exp) $display("FAIL rstmid_retry c=%0d got %b exp %b", c, st, exp);
      else passed++;
      if (c == 4) begin
        dm_req = 1'b0;
        dm_we = 1'b0;
      end
    end
  endtask

  task automatic test_drop();
    logic [4:0] exp;
    do_reset();
    fixed_rdata = 32'h0BAD_F00D;
    dm_addr = 32'h1001_0008;
    dm_we = 1'b0;
    dm_req = 1'b1;
    for (int c = 1; c <= 9; c++) begin
      @(negedge clk);
      if (c <= 4) exp = {1'b1, c <= 3, 1'b0, 1'b0, c == 4};
      else exp = 5'b00000;
      total++;
      if (st !== exp) $display("FAIL drop_ctl c=%0d got %b exp %b", c, st, exp);
      else passed++;
      if (c == 1) begin
        if_addr = 32'h0040_0040;
        if_req = 1'b1;
      end
      if (c == 3) if_req = 1'b0;
      if (c == 4) begin
        total++;
        if (rdata !== 32'h0BAD_F00D)
          $display("FAIL drop_rdata got %h exp 0badf00d", rdata);
        else passed++;
        dm_req = 1'b0;
      end
    end
  endtask

  task automatic test_lat1();
    logic [4:0] exp;
    do_reset();
    fixed_rdata = 32'h1234_5678;
    dm_addr = 32'h1001_000C;
    dm_we = 1'b0;
    dm_req = 1'b1;
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      exp = {c <= 2, c == 1, 1'b0, 1'b0, c == 2};
      total++;
      if (st1 !== exp) $display("FAIL lat1_ctl c=%0d got %b exp %b", c, st1, exp);
      else passed++;
      if (c == 2) begin
        total++;
        if (rdata_1 !== 32'h1234_5678)
          $display("FAIL lat1_rdata got %h exp 12345678", rdata_1);
        else passed++;
        dm_req = 1'b0;
      end
    end
  endtask

  // Reference model: one transaction at a time, described by its grant
  // cycle; all outputs follow from the phase relative to that grant.
  task automatic test_random();
    logic [DW-1:0] ref_mem [16];
    bit            act = 1'b0;
    int            t0 = 0;
    bit            own = 1'b0;
    bit            last = 1'b0;
    bit            mwe = 1'b0;
    logic [AW-1:0] maddr = '0;
    logic [DW-1:0] mwd = '0;
    logic [DW-1:0] mrd = '0;
    int            ph;
    bit            acc, done, idle_now;
    logic [4:0]    exp;
    for (int i = 0; i < 16; i++) ref_mem[i] = 32'hA5A5_0000 | i;
    use_mem = 1'b1;
    do_reset();
    for (int n = 0; n < NCYC; n++) begin
      if (n > 0) @(negedge clk);
      ph = n - t0;
      idle_now = !act;
      acc = act && ph >= 1 && ph <= LAT;
      done = act && ph == LAT + 1;
      if (done) begin
        if (mwe) ref_mem[maddr[5:2]] = mwd;
        else mrd = ref_mem[maddr[5:2]];
      end
      exp = {acc || done, acc, acc && mwe && ph == LAT, done && !own, done && own};
      total++;
      if (st !== exp) $display("FAIL rand_ctl n=%0d got %b exp %b", n, st, exp);
      else passed++;
      total++;
      if (rdata !== mrd) $display("FAIL rand_rdata n=%0d got %h exp %h", n, rdata, mrd);
      else passed++;
      if (acc) begin
        total++;
        if (mem_addr !== maddr)
          $display("FAIL rand_addr n=%0d got %h exp %h", n, mem_addr, maddr);
        else passed++;
        if (mwe) begin
          total++;
          if (mem_wdata !== mwd)
            $display("FAIL rand_wdata n=%0d got %h exp %h", n, mem_wdata, mwd);
          else passed++;
        end
      end
      if (done) begin
        act = 1'b0;
        if (own) dm_req = 1'b0;
        else if_req = 1'b0;
      end
      if (if_req && !(act && !own) && $urandom_range(0, 7) == 0) if_req = 1'b0;
      if (dm_req && !(act && own) && $urandom_range(0, 7) == 0) dm_req = 1'b0;
      if (!if_req && n < NCYC - 15 && $urandom_range(0, 2) == 0) begin
        if_req = 1'b1;
        if_addr = $urandom;
      end
      if (!dm_req && n < NCYC - 15 && $urandom_range(0, 2) == 0) begin
        dm_req = 1'b1;
        dm_we = 1'($urandom_range(0, 1));
        dm_addr = $urandom;
        dm_wdata = $urandom;
      end
      if (idle_now && (if_req || dm_req)) begin
        own = (if_req && dm_req) ? !last : dm_req;
        last = own;
        act = 1'b1;
        t0 = n;
        mwe = own && dm_we;
        maddr = own ? dm_addr : if_addr;
        mwd = own ? dm_wdata : '0;
      end
    end
    if_req = 1'b0;
    dm_req = 1'b0;
    repeat (LAT + 3) @(negedge clk);
    total++;
    if (busy !== 1'b0) $display("FAIL rand_drain got %b exp 0", busy);
    else passed++;
    use_mem = 1'b0;
  endtask

  initial begin
    test_reset();
    test_fetch();
    test_store();
    test_contention();
    test_reset_mid_store();
    test_drop();
    test_lat1();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
